// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: op enum, opcode/funct
// constants, request payload and the word-building helpers.
package instr_encoder_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_SLT   = 5'd4,
        OP_LW    = 5'd5,
        OP_SW    = 5'd6,
        OP_BEQ   = 5'd7,
        OP_BNE   = 5'd8,
        OP_ADDI  = 5'd9,
        OP_J     = 5'd10,
        OP_JAL   = 5'd11,
        OP_ANDI  = 5'd12,
        OP_ORI   = 5'd13,
        OP_XORI  = 5'd14,
        OP_SLTI  = 5'd15,
        OP_SLTIU = 5'd16,
        OP_LUI   = 5'd17
    } op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
        logic [TGT_W-1:0] target;
    } req_t;

    localparam logic [OPC_W-1:0] OPC_SPECIAL = 6'd0;
    localparam logic [OPC_W-1:0] OPC_J       = 6'd2;
    localparam logic [OPC_W-1:0] OPC_JAL     = 6'd3;
    localparam logic [OPC_W-1:0] OPC_BEQ     = 6'd4;
    localparam logic [OPC_W-1:0] OPC_BNE     = 6'd5;
    localparam logic [OPC_W-1:0] OPC_ADDI    = 6'd8;
    localparam logic [OPC_W-1:0] OPC_SLTI    = 6'd10;
    localparam logic [OPC_W-1:0] OPC_SLTIU   = 6'd11;
    localparam logic [OPC_W-1:0] OPC_ANDI    = 6'd12;
    localparam logic [OPC_W-1:0] OPC_ORI     = 6'd13;
    localparam logic [OPC_W-1:0] OPC_XORI    = 6'd14;
    localparam logic [OPC_W-1:0] OPC_LUI     = 6'd15;
    localparam logic [OPC_W-1:0] OPC_LW      = 6'd35;
    localparam logic [OPC_W-1:0] OPC_SW      = 6'd43;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'd32;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'd34;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'd36;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'd37;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'd42;

    // Codes above OP_LUI are reserved and must be dropped.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op <= OP_LUI;
    endfunction

    function automatic logic [WORD_W-1:0] enc_r(input logic [FUNCT_W-1:0] funct,
                                                input logic [REG_W-1:0]   rs,
                                                input logic [REG_W-1:0]   rt,
                                                input logic [REG_W-1:0]   rd);
        return {OPC_SPECIAL, rs, rt, rd, SHAMT_W'(0), funct};
    endfunction

    function automatic logic [WORD_W-1:0] enc_i(input logic [OPC_W-1:0] opc,
                                                input logic [REG_W-1:0] rs,
                                                input logic [REG_W-1:0] rt,
                                                input logic [IMM_W-1:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [WORD_W-1:0] enc_j(input logic [OPC_W-1:0] opc,
                                                input logic [TGT_W-1:0] target);
        return {opc, target};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-word handshake bundle for instr_encoder, plus the
// sticky status flags.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    import instr_encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [REG_W-1:0]  in_rs;
    logic [REG_W-1:0]  in_rt;
    logic [REG_W-1:0]  in_rd;
    logic [IMM_W-1:0]  in_imm;
    logic [TGT_W-1:0]  in_target;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [ADDR_W-1:0] out_addr;

    logic              illegal;
    logic              wrapped;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_word, out_addr, illegal, wrapped
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_word, out_addr, illegal, wrapped
    );

endinterface

// File: rtl/instr_pack.sv
// Combinational MIPS encoder: request fields in, instruction word and
// legal-op flag out (both outputs are unregistered).
module instr_pack
    import instr_encoder_pkg::*;
(
    input  req_t              req_i,
    output logic [WORD_W-1:0] word_c_o,
    output logic              legal_c_o
);

    always_comb begin
        word_c_o  = '0;
        legal_c_o = is_legal_op(req_i.op);
        case (req_i.op)
            OP_ADD:   word_c_o = enc_r(FN_ADD, req_i.rs, req_i.rt, req_i.rd);
            OP_SUB:   word_c_o = enc_r(FN_SUB, req_i.rs, req_i.rt, req_i.rd);
            OP_AND:   word_c_o = enc_r(FN_AND, req_i.rs, req_i.rt, req_i.rd);
            OP_OR:    word_c_o = enc_r(FN_OR,  req_i.rs, req_i.rt, req_i.rd);
            OP_SLT:   word_c_o = enc_r(FN_SLT, req_i.rs, req_i.rt, req_i.rd);
            OP_LW:    word_c_o = enc_i(OPC_LW,    req_i.rs, req_i.rt, req_i.imm);
            OP_SW:    word_c_o = enc_i(OPC_SW,    req_i.rs, req_i.rt, req_i.imm);
            OP_BEQ:   word_c_o = enc_i(OPC_BEQ,   req_i.rs, req_i.rt, req_i.imm);
            OP_BNE:   word_c_o = enc_i(OPC_BNE,   req_i.rs, req_i.rt, req_i.imm);
            OP_ADDI:  word_c_o = enc_i(OPC_ADDI,  req_i.rs, req_i.rt, req_i.imm);
            OP_ANDI:  word_c_o = enc_i(OPC_ANDI,  req_i.rs, req_i.rt, req_i.imm);
            OP_ORI:   word_c_o = enc_i(OPC_ORI,   req_i.rs, req_i.rt, req_i.imm);
            OP_XORI:  word_c_o = enc_i(OPC_XORI,  req_i.rs, req_i.rt, req_i.imm);
            OP_SLTI:  word_c_o = enc_i(OPC_SLTI,  req_i.rs, req_i.rt, req_i.imm);
            OP_SLTIU: word_c_o = enc_i(OPC_SLTIU, req_i.rs, req_i.rt, req_i.imm);
            // LUI has no source register; rs is forced to zero.
            OP_LUI:   word_c_o = enc_i(OPC_LUI, REG_W'(0), req_i.rt, req_i.imm);
            OP_J:     word_c_o = enc_j(OPC_J,   req_i.target);
            OP_JAL:   word_c_o = enc_j(OPC_JAL, req_i.target);
            default:  word_c_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes requests into MIPS words and buffers them in a 2-entry output FIFO,
// tagging each word with a wrapping instruction-memory address.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    fifo_state_e       state_q, state_d;
    logic [WORD_W-1:0] head_word_q, head_word_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic [WORD_W-1:0] tail_word_q, tail_word_d;
    logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              out_valid_q, out_valid_d;
    logic              illegal_q, illegal_d;
    logic              wrapped_q, wrapped_d;

    req_t              req;
    logic [WORD_W-1:0] pack_word;
    logic              pack_legal;
    logic              in_ready_c;
    logic              accept;
    logic              push;
    logic              pop;

    assign req = '{op:     bus.in_op,
                   rs:     bus.in_rs,
                   rt:     bus.in_rt,
                   rd:     bus.in_rd,
                   imm:    bus.in_imm,
                   target: bus.in_target};

    instr_pack u_pack (
        .req_i     (req),
        .word_c_o  (pack_word),
        .legal_c_o (pack_legal)
    );

    // A pop in the same cycle does not open the FIFO to a third word.
    assign in_ready_c = (state_q != ST_FULL);
    assign accept     = bus.in_valid && in_ready_c;
    assign push       = accept && pack_legal;
    assign pop        = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            head_word_q <= '0;
            head_addr_q <= BASE;
            tail_word_q <= '0;
            tail_addr_q <= BASE;
            addr_q      <= BASE;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_word_q <= head_word_d;
            head_addr_q <= head_addr_d;
            tail_word_q <= tail_word_d;
            tail_addr_q <= tail_addr_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            wrapped_q   <= wrapped_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        head_word_d = head_word_q;
        head_addr_d = head_addr_q;
        tail_word_d = tail_word_q;
        tail_addr_d = tail_addr_q;
        addr_d      = addr_q;
        illegal_d   = illegal_q;
        wrapped_d   = wrapped_q;

        if (restart) begin
            state_d   = ST_EMPTY;
            addr_d    = BASE;
            illegal_d = 1'b0;
            wrapped_d = 1'b0;
        end else begin
            if (accept && !pack_legal) begin
                illegal_d = 1'b1;
            end
            if (push) begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == '1) begin
                    wrapped_d = 1'b1;
                end
            end

            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_word_d = pack_word;
                        head_addr_d = addr_q;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_word_d = pack_word;
                        head_addr_d = addr_q;
                    end else if (push) begin
                        tail_word_d = pack_word;
                        tail_addr_d = addr_q;
                        state_d     = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_word_d = tail_word_q;
                        head_addr_d = tail_addr_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = head_word_q;
    assign bus.out_addr  = head_addr_q;
    assign bus.illegal   = illegal_q;
    assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench: two encoders (8-bit and 2-bit address) share one stimulus
// stream and are checked against a table-driven MIPS encoding model.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset;
    logic restart;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(8)) b8 ();
    instr_encoder_if #(.ADDR_W(2)) b2 ();

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
        .clk(clk), .reset(reset), .restart(restart), .bus(b8));
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .restart(restart), .bus(b2));

    typedef struct {
        logic [31:0] word;
        int          a8;
        int          a2;
    } exp_t;

    exp_t q[$];
    int   addr8, addr2;
    bit   ill, wr8, wr2;
    int   pend;
    int   errors = 0;
    int   checks = 0;

    int unsigned opc_tab [18] = '{0, 0, 0, 0, 0, 35, 43, 4, 5, 8, 2, 3, 12, 13, 14, 10, 11, 15};
    int unsigned fn_tab  [5]  = '{32, 34, 36, 37, 42};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the format tables: R, J, or I (LUI drops rs).
    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int imm, input int tgt);
        int unsigned w;
        if (op < 5) begin
            w = (rs << 21) + (rt << 16) + (rd << 11) + fn_tab[op];
        end else if (op == 10 || op == 11) begin
            w = (opc_tab[op] << 26) + tgt;
        end else begin
            w = (opc_tab[op] << 26) + ((op == 17 ? 0 : rs) << 21) + (rt << 16) + imm;
        end
        return 32'(w);
    endfunction

    task automatic clear_model();
        q.delete();
        addr8 = 0;
        addr2 = 0;
        ill   = 1'b0;
        wr8   = 1'b0;
        wr2   = 1'b0;
        pend  = 0;
    endtask

    // Monitor: compares the presented word against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && !restart) begin
            check("out_valid8", 64'(b8.out_valid), 64'((q.size() - pend) > 0));
            check("out_valid2", 64'(b2.out_valid), 64'((q.size() - pend) > 0));
            if (b8.out_valid && q.size() > 0) begin
                check("out_word8", 64'(b8.out_word), 64'(q[0].word));
                check("out_addr8", 64'(b8.out_addr), 64'(q[0].a8));
                check("out_word2", 64'(b2.out_word), 64'(q[0].word));
                check("out_addr2", 64'(b2.out_addr), 64'(q[0].a2));
                if (b8.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        check("in_ready8", 64'(b8.in_ready), 64'(q.size() < 2));
        check("in_ready2", 64'(b2.in_ready), 64'(q.size() < 2));
        check("illegal8",  64'(b8.illegal), 64'(ill));
        check("illegal2",  64'(b2.illegal), 64'(ill));
        check("wrapped8",  64'(b8.wrapped), 64'(wr8));
        check("wrapped2",  64'(b2.wrapped), 64'(wr2));
    endtask

    task automatic drive(input bit v, input int op, input int rs, input int rt, input int rd,
                         input int imm, input int tgt, input bit ordy, input bit rst_t,
                         input bit use_exp, input logic [31:0] exp_w, output bit acc);
        exp_t e;
        b8.in_valid = v;  b2.in_valid = v;
        b8.in_op = 5'(op); b2.in_op = 5'(op);
        b8.in_rs = 5'(rs); b2.in_rs = 5'(rs);
        b8.in_rt = 5'(rt); b2.in_rt = 5'(rt);
        b8.in_rd = 5'(rd); b2.in_rd = 5'(rd);
        b8.in_imm = 16'(imm); b2.in_imm = 16'(imm);
        b8.in_target = 26'(tgt); b2.in_target = 26'(tgt);
        b8.out_ready = ordy; b2.out_ready = ordy;
        restart = rst_t;
        pend = 0;
        acc  = 1'b0;
        if (rst_t) begin
            clear_model();
        end else if (v && q.size() < 2) begin
            acc = 1'b1;
            if (op > 17) begin
                ill = 1'b1;
            end else begin
                e.word = use_exp ? exp_w : ref_word(op, rs, rt, rd, imm, tgt);
                e.a8 = addr8;
                e.a2 = addr2;
                q.push_back(e);
                pend = 1;
                addr8++;
                if (addr8 == 256) begin addr8 = 0; wr8 = 1'b1; end
                addr2++;
                if (addr2 == 4) begin addr2 = 0; wr2 = 1'b1; end
            end
        end
    endtask

    task automatic issue(input int op, input int rs, input int rt, input int rd, input int imm,
                         input int tgt, input bit ordy, input bit use_exp, input logic [31:0] exp_w);
        bit acc;
        for (int i = 0; i < 40; i++) begin
            tick();
            drive(1'b1, op, rs, rt, rd, imm, tgt, ordy, 1'b0, use_exp, exp_w, acc);
            if (acc) return;
        end
        errors++;
        checks++;
        $display("FAIL issue_timeout: op %0d not accepted within 40 cycles", op);
    endtask

    task automatic idle(input bit ordy, input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            tick();
            drive(1'b0, 0, 0, 0, 0, 0, 0, ordy, 1'b0, 1'b0, 32'h0, acc);
        end
    endtask

    task automatic do_restart(input bit v, input bit ordy);
        bit acc;
        tick();
        drive(v, 1, 3, 4, 5, 0, 0, ordy, 1'b1, 1'b0, 32'h0, acc);
    endtask

    initial begin
        bit acc;
        clear_model();
        reset   = 1'b1;
        restart = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, acc);
        #12;
        check("rst_out_valid", 64'(b8.out_valid), 64'd0);
        check("rst_out_word",  64'(b8.out_word),  64'd0);
        check("rst_out_addr",  64'(b8.out_addr),  64'd0);
        check("rst_illegal",   64'(b8.illegal),   64'd0);
        check("rst_wrapped",   64'(b2.wrapped),   64'd0);
        check("rst_in_ready",  64'(b8.in_ready),  64'd1);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(b8.in_ready), 64'd1);

        // Golden encodings.
        issue(0, 1, 2, 3, 0, 0, 1'b1, 1'b1, 32'h0022_1820);
        idle(1'b1, 2);
        issue(5, 29, 8, 0, 16'h0004, 0, 1'b1, 1'b1, 32'h8FA8_0004);
        issue(10, 0, 0, 0, 0, 26'h10, 1'b1, 1'b1, 32'h0800_0010);
        issue(17, 7, 5, 0, 16'h1234, 0, 1'b1, 1'b1, 32'h3C05_1234);
        idle(1'b1, 3);

        // Back-pressure: two fill the FIFO, third waits for a drain.
        do_restart(1'b0, 1'b1);
        issue(1, 4, 5, 6, 0, 0, 1'b0, 1'b0, 32'h0);
        issue(6, 7, 8, 0, 16'hBEEF, 0, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 3);
        issue(3, 9, 10, 11, 0, 0, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 3);

        // Undefined op is swallowed without consuming an address.
        issue(20, 1, 1, 1, 1, 1, 1'b1, 1'b0, 32'h0);
        issue(9, 2, 3, 0, 16'h7FFF, 0, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 3);

        // Address wrap on the 2-bit instance.
        do_restart(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) issue(12 + i, i, i + 1, 0, 100 * i, 0, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 3);

        // Restart while full with a pending request.
        issue(25, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        issue(2, 1, 2, 3, 0, 0, 1'b0, 1'b0, 32'h0);
        issue(11, 0, 0, 0, 0, 26'h3FF_FFFF, 1'b0, 1'b0, 32'h0);
        do_restart(1'b1, 1'b0);
        issue(4, 31, 30, 29, 0, 0, 1'b1, 1'b0, 32'h0);
        idle(1'b1, 3);

        // Asynchronous reset with two words buffered.
        issue(7, 1, 2, 0, 16'hFFFF, 0, 1'b0, 1'b0, 32'h0);
        issue(8, 3, 4, 0, 16'h0001, 0, 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        clear_model();
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0, acc);
        #1;
        check("midrst_out_valid", 64'(b8.out_valid), 64'd0);
        check("midrst_in_ready",  64'(b2.in_ready),  64'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        idle(1'b1, 3);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int op;
            tick();
            op = ($urandom_range(7) == 0) ? 18 + $urandom_range(13) : $urandom_range(17);
            drive($urandom_range(3) != 0, op, $urandom_range(31), $urandom_range(31),
                  $urandom_range(31), $urandom_range(65535), int'($urandom_range(26'h3FF_FFFF)),
                  $urandom_range(3) != 0, $urandom_range(59) == 0, 1'b0, 32'h0, acc);
        end
        idle(1'b1, 6);
        check("drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
